// File: rtl/fifo_umbrales.sv
// ---------------------------------------------------------------------------
// fifo_umbrales
//
// Threshold-aware synchronous FIFO. It buffers DATA_WIDTH-bit words in a
// 2^ADDR_WIDTH-deep register array and reports occupancy status against a
// low threshold (bajo) and a high threshold (alto) that are supplied live
// by the controlling state machine. Overflow and underflow requests are
// rejected without disturbing the stored data and latch a sticky error flag
// that only reset clears.
//
// Ports
//   clk           : single clock, all state changes on the rising edge
//   reset         : synchronous, active-high; overrides push/pop
//   push          : write request, data_in captured on the same edge
//   data_in       : write data
//   pop           : read request
//   bajo          : low threshold  (almost_empty = count <= bajo)
//   alto          : high threshold (almost_full  = count >= alto)
//   data_out      : registered read data, holds between pops
//   valid_out     : data_out carries a word popped on the previous edge
//   fifo_empty    : count == 0
//   fifo_full     : count == 2^ADDR_WIDTH
//   almost_empty  : count <= bajo
//   almost_full   : count >= alto
//   error_out     : sticky overflow/underflow indication
//   count         : current occupancy, 0 .. 2^ADDR_WIDTH
// ---------------------------------------------------------------------------
module fifo_umbrales #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    input  logic [ADDR_WIDTH-1:0] bajo,
    input  logic [ADDR_WIDTH-1:0] alto,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic                  error_out,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Count is one bit wider than the pointers so that "full" (DEPTH) is
    // distinguishable from "empty" (0) without comparing pointers.
    localparam logic [ADDR_WIDTH:0]   CNT_ZERO = (ADDR_WIDTH+1)'(0);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] PTR_ZERO = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = DATA_WIDTH'(0);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [ADDR_WIDTH-1:0] rd_ptr_r;
    logic [ADDR_WIDTH:0]   count_r;
    logic [DATA_WIDTH-1:0] data_out_r;
    logic                  valid_r;
    logic                  error_r;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic                  empty_s;
    logic                  full_s;
    logic                  push_acc_s;
    logic                  pop_acc_s;
    logic                  overflow_s;
    logic                  underflow_s;
    logic [ADDR_WIDTH:0]   count_nxt_s;
    logic [ADDR_WIDTH-1:0] wr_ptr_nxt_s;
    logic [ADDR_WIDTH-1:0] rd_ptr_nxt_s;
    logic                  error_nxt_s;
    logic                  almost_empty_s;
    logic                  almost_full_s;

    // Occupancy status derived from the registered count.
    always_comb begin
        empty_s = (count_r == CNT_ZERO);
        full_s  = (count_r == CNT_FULL);
    end

    // Threshold compares use the live thresholds so a reprogrammed value
    // is reflected in the same cycle; no clamping is applied.
    always_comb begin
        almost_empty_s = (count_r <= {1'b0, bajo});
        almost_full_s  = (count_r >= {1'b0, alto});
    end

    // Request acceptance. A push into a full FIFO is still accepted when a
    // pop frees the oldest slot on the same edge: the write lands in the
    // slot being read, and the nonblocking read picks up the old word.
    // A pop from an empty FIFO is never accepted, even alongside a push,
    // because the pushed word is not readable until the next edge.
    always_comb begin
        push_acc_s  = push & (~full_s | pop);
        pop_acc_s   = pop & ~empty_s;
        overflow_s  = push & full_s & ~pop;
        underflow_s = pop & empty_s;
    end

    // Next-state for occupancy, pointers and the sticky error flag.
    always_comb begin
        count_nxt_s  = count_r;
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        error_nxt_s  = error_r | overflow_s | underflow_s;

        case ({push_acc_s, pop_acc_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase

        if (push_acc_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end

        if (pop_acc_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
    end

    // Control state: pointers, occupancy and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
            error_r  <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            error_r  <= error_nxt_s;
        end
    end

    // Storage array; contents are not reset, only the pointers are.
    always_ff @(posedge clk) begin
        if (!reset && push_acc_s) begin
            mem_r[wr_ptr_r] <= data_in;
        end
    end

    // Registered read port: data_out holds its value between pops while
    // valid_out marks the single cycle following each accepted pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_r <= DATA_ZERO;
            valid_r    <= 1'b0;
        end else if (pop_acc_s) begin
            data_out_r <= mem_r[rd_ptr_r];
            valid_r    <= 1'b1;
        end else begin
            data_out_r <= data_out_r;
            valid_r    <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign data_out     = data_out_r;
    assign valid_out    = valid_r;
    assign fifo_empty   = empty_s;
    assign fifo_full    = full_s;
    assign almost_empty = almost_empty_s;
    assign almost_full  = almost_full_s;
    assign error_out    = error_r;
    assign count        = count_r;

endmodule

// File: tb/tb_fifo_umbrales.sv
// ---------------------------------------------------------------------------
// tb_fifo_umbrales
//
// Directed, table-driven bench for fifo_umbrales. A vector table covers
// reset, fill/drain, threshold behaviour, underflow and the empty
// push+pop case; hand-written sequences cover overflow, full push+pop,
// pointer wrap and reset in the middle of operation.
// ---------------------------------------------------------------------------
module tb_fifo_umbrales;

    logic       clk;
    logic       reset;
    logic       push;
    logic [5:0] data_in;
    logic       pop;
    logic [2:0] bajo;
    logic [2:0] alto;
    logic [5:0] data_out;
    logic       valid_out;
    logic       fifo_empty;
    logic       fifo_full;
    logic       almost_empty;
    logic       almost_full;
    logic       error_out;
    logic [3:0] count;

    int n_checks;
    int n_errors;

    fifo_umbrales #(.DATA_WIDTH(6), .ADDR_WIDTH(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .data_in      (data_in),
        .pop          (pop),
        .bajo         (bajo),
        .alto         (alto),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .error_out    (error_out),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       psh;
        logic       pp;
        logic [5:0] din;
        logic [2:0] lo;
        logic [2:0] hi;
        logic [3:0] cnt;
        logic       e;
        logic       f;
        logic       ae;
        logic       af;
        logic       v;
        logic [5:0] dout;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic rst, input logic psh, input logic pp, input logic [5:0] din,
        input logic [2:0] lo, input logic [2:0] hi,
        input logic [3:0] cnt, input logic e, input logic f, input logic ae,
        input logic af, input logic v, input logic [5:0] dout, input logic err);
        vec_t t;
        t.rst = rst; t.psh = psh; t.pp = pp; t.din = din; t.lo = lo; t.hi = hi;
        t.cnt = cnt; t.e = e; t.f = f; t.ae = ae; t.af = af; t.v = v;
        t.dout = dout; t.err = err;
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, sample 1 time unit after the edge.
    task automatic step(input logic rst, input logic psh, input logic pp,
                        input logic [5:0] din);
        reset   = rst;
        push    = psh;
        pop     = pp;
        data_in = din;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_status(input string name, input int idx, input int cnt,
                              input int v, input int dout, input int err);
        chk({name, ".count"}, idx, int'(count), cnt);
        chk({name, ".valid"}, idx, int'(valid_out), v);
        chk({name, ".dout"},  idx, int'(data_out), dout);
        chk({name, ".err"},   idx, int'(error_out), err);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b0; push = 1'b0; pop = 1'b0; data_in = 6'h00;
        bajo = 3'd2; alto = 3'd6;

        //                rst psh pop din    lo    hi     cnt   e    f    ae   af   v    dout   err
        vecs.push_back(mk(1'b1,1'b1,1'b1,6'h00,3'd2,3'd6, 4'd0,1'b1,1'b0,1'b1,1'b0,1'b0,6'h00,1'b0));
        vecs.push_back(mk(1'b1,1'b1,1'b1,6'h00,3'd2,3'd6, 4'd0,1'b1,1'b0,1'b1,1'b0,1'b0,6'h00,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,6'h00,3'd2,3'd6, 4'd0,1'b1,1'b0,1'b1,1'b0,1'b0,6'h00,1'b0));
        // Fill one word at a time against bajo=2 / alto=6
        vecs.push_back(mk(1'b0,1'b1,1'b0,6'h01,3'd2,3'd6, 4'd1,1'b0,1'b0,1'b1,1'b0,1'b0,6'h00,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,6'h02,3'd2,3'd6, 4'd2,1'b0,1'b0,1'b1,1'b0,1'b0,6'h00,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,6'h03,3'd2,3'd6, 4'd3,1'b0,1'b0,1'b0,1'b0,1'b0,6'h00,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,6'h04,3'd2,3'd6, 4'd4,1'b0,1'b0,1'b0,1'b0,1'b0,6'h00,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,6'h05,3'd2,3'd6, 4'd5,1'b0,1'b0,1'b0,1'b0,1'b0,6'h00,1'b0));
        // alto lowered to 4 at count 5, then restored
        vecs.push_back(mk(1'b0,1'b0,1'b0,6'h00,3'd2,3'd4, 4'd5,1'b0,1'b0,1'b0,1'b1,1'b0,6'h00,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,6'h00,3'd2,3'd6, 4'd5,1'b0,1'b0,1'b0,1'b0,1'b0,6'h00,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,6'h06,3'd2,3'd6, 4'd6,1'b0,1'b0,1'b0,1'b1,1'b0,6'h00,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,6'h07,3'd2,3'd6, 4'd7,1'b0,1'b0,1'b0,1'b1,1'b0,6'h00,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,6'h08,3'd2,3'd6, 4'd8,1'b0,1'b1,1'b0,1'b1,1'b0,6'h00,1'b0));
        // Drain: in-order data, valid every cycle
        vecs.push_back(mk(1'b0,1'b0,1'b1,6'h00,3'd2,3'd6, 4'd7,1'b0,1'b0,1'b0,1'b1,1'b1,6'h01,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b1,6'h00,3'd2,3'd6, 4'd6,1'b0,1'b0,1'b0,1'b1,1'b1,6'h02,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b1,6'h00,3'd2,3'd6, 4'd5,1'b0,1'b0,1'b0,1'b0,1'b1,6'h03,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b1,6'h00,3'd2,3'd6, 4'd4,1'b0,1'b0,1'b0,1'b0,1'b1,6'h04,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b1,6'h00,3'd2,3'd6, 4'd3,1'b0,1'b0,1'b0,1'b0,1'b1,6'h05,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b1,6'h00,3'd2,3'd6, 4'd2,1'b0,1'b0,1'b1,1'b0,1'b1,6'h06,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b1,6'h00,3'd2,3'd6, 4'd1,1'b0,1'b0,1'b1,1'b0,1'b1,6'h07,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b1,6'h00,3'd2,3'd6, 4'd0,1'b1,1'b0,1'b1,1'b0,1'b1,6'h08,1'b0));
        // Idle: valid drops, data holds
        vecs.push_back(mk(1'b0,1'b0,1'b0,6'h00,3'd2,3'd6, 4'd0,1'b1,1'b0,1'b1,1'b0,1'b0,6'h08,1'b0));
        // Underflow is sticky
        vecs.push_back(mk(1'b0,1'b0,1'b1,6'h00,3'd2,3'd6, 4'd0,1'b1,1'b0,1'b1,1'b0,1'b0,6'h08,1'b1));
        vecs.push_back(mk(1'b0,1'b0,1'b0,6'h00,3'd2,3'd6, 4'd0,1'b1,1'b0,1'b1,1'b0,1'b0,6'h08,1'b1));
        // Reset clears error and data_out
        vecs.push_back(mk(1'b1,1'b0,1'b0,6'h00,3'd2,3'd6, 4'd0,1'b1,1'b0,1'b1,1'b0,1'b0,6'h00,1'b0));
        // bajo=0: almost_empty follows fifo_empty; empty push+pop is underflow
        vecs.push_back(mk(1'b0,1'b0,1'b0,6'h00,3'd0,3'd6, 4'd0,1'b1,1'b0,1'b1,1'b0,1'b0,6'h00,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b1,6'h15,3'd0,3'd6, 4'd1,1'b0,1'b0,1'b0,1'b0,1'b0,6'h00,1'b1));
        // Pushed word readable on the next edge
        vecs.push_back(mk(1'b0,1'b0,1'b1,6'h00,3'd0,3'd6, 4'd0,1'b1,1'b0,1'b1,1'b0,1'b1,6'h15,1'b1));
        // Reset with alto=0: almost_full asserted at count 0
        vecs.push_back(mk(1'b1,1'b0,1'b0,6'h00,3'd2,3'd0, 4'd0,1'b1,1'b0,1'b1,1'b1,1'b0,6'h00,1'b0));

        foreach (vecs[i]) begin
            bajo = vecs[i].lo;
            alto = vecs[i].hi;
            step(vecs[i].rst, vecs[i].psh, vecs[i].pp, vecs[i].din);
            chk("vec.count", i, int'(count),        int'(vecs[i].cnt));
            chk("vec.empty", i, int'(fifo_empty),   int'(vecs[i].e));
            chk("vec.full",  i, int'(fifo_full),    int'(vecs[i].f));
            chk("vec.ae",    i, int'(almost_empty), int'(vecs[i].ae));
            chk("vec.af",    i, int'(almost_full),  int'(vecs[i].af));
            chk("vec.valid", i, int'(valid_out),    int'(vecs[i].v));
            chk("vec.dout",  i, int'(data_out),     int'(vecs[i].dout));
            chk("vec.err",   i, int'(error_out),    int'(vecs[i].err));
        end

        // ---- Full push+pop, then overflow, then drain ----
        bajo = 3'd2; alto = 3'd6;
        step(1'b1, 1'b0, 1'b0, 6'h00);
        for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 1'b0, 6'(8'h11 + k));
        chk("fill.full", 0, int'(fifo_full), 1);
        chk_status("fill", 0, 8, 0, 6'h00, 0);
        step(1'b0, 1'b1, 1'b1, 6'h2A);
        chk_status("fullpp", 0, 8, 1, 6'h11, 0);
        chk("fullpp.full", 0, int'(fifo_full), 1);
        step(1'b0, 1'b1, 1'b0, 6'h3F);
        chk_status("ovf", 0, 8, 0, 6'h11, 1);
        begin
            logic [5:0] exp_drain [8];
            for (int k = 0; k < 7; k++) exp_drain[k] = 6'(8'h12 + k);
            exp_drain[7] = 6'h2A;
            for (int k = 0; k < 8; k++) begin
                step(1'b0, 1'b0, 1'b1, 6'h00);
                chk_status("drain", k, 7 - k, 1, int'(exp_drain[k]), 1);
            end
        end
        chk("drain.empty", 0, int'(fifo_empty), 1);

        // ---- Alternating push/pop so both pointers wrap twice ----
        step(1'b1, 1'b0, 1'b0, 6'h00);
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b1, 1'b0, 6'((k * 3 + 5) % 64));
            chk("wrap.cnt1", k, int'(count), 1);
            step(1'b0, 1'b0, 1'b1, 6'h00);
            chk_status("wrap", k, 0, 1, (k * 3 + 5) % 64, 0);
        end

        // ---- Reset while holding five words; old data must never appear ----
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0, 6'(8'h21 + k));
        chk("mid.count", 0, int'(count), 5);
        step(1'b1, 1'b0, 1'b1, 6'h00);
        chk_status("midrst", 0, 0, 0, 6'h00, 0);
        chk("midrst.empty", 0, int'(fifo_empty), 1);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'b1, 6'h00);
            chk_status("postrst", k, 0, 0, 6'h00, 1);
        end

        step(1'b0, 1'b0, 1'b0, 6'h00);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_umbrales.md
# fifo_umbrales

Threshold-aware FIFO that sits on the far side of `maquina_de_estados`: it consumes the low/high thresholds the state machine programs and returns the empty status the state machine monitors. Eight instances form the FIFO bank; each `fifo_empty` bit drives one bit of the machine's `empty_fifos[7:0]`. The block buffers data words and reports empty/full, almost-empty/almost-full and overflow/underflow error status.

## Interface

- `DATA_WIDTH`, 6: width of a data word.
- `ADDR_WIDTH`, 3: pointer width; depth = 2^ADDR_WIDTH (8).

- `clk`  input  1  single clock, all logic on the rising edge.
- `reset`  input  1  synchronous, active-high.
- `push`  input  1  write request; `data_in` is captured on the same edge.
- `data_in`  input  DATA_WIDTH  write data.
- `pop`  input  1  read request.
- `bajo`  input  ADDR_WIDTH  low threshold (from the state machine's `bajo_out` slice).
- `alto`  input  ADDR_WIDTH  high threshold (from the state machine's `alto_out` slice).
- `data_out`  output  DATA_WIDTH  registered read data.
- `valid_out`  output  1  `data_out` holds a word popped on the previous edge.
- `fifo_empty`  output  1  count == 0.
- `fifo_full`  output  1  count == 2^ADDR_WIDTH.
- `almost_empty`  output  1  count <= `bajo`.
- `almost_full`  output  1  count >= `alto`.
- `error_out`  output  1  sticky overflow/underflow flag.
- `count`  output  ADDR_WIDTH+1  current occupancy.

## Operation

- Storage: 2^ADDR_WIDTH × DATA_WIDTH register array, write pointer `wr_ptr` and read pointer `rd_ptr` (ADDR_WIDTH bits each, natural wrap from 7 to 0), occupancy counter `count` (0..8).
- Reset (`reset` high on an edge): `wr_ptr = rd_ptr = 0`, `count = 0`, `data_out = 0`, `valid_out = 0`, `error_out = 0`. Array contents are don't-care. Resulting outputs: `fifo_empty = 1`, `fifo_full = 0`, `almost_empty = 1`, `almost_full = (alto == 0)`. Reset overrides `push`/`pop` in the same cycle and aborts any operation in progress.
- Accepted push (`push` & !full, or `push` & `pop` & full): `mem[wr_ptr] <= data_in`, `wr_ptr++`.
- Accepted pop (`pop` & !empty): `data_out <= mem[rd_ptr]`, `valid_out <= 1`, `rd_ptr++`. In any cycle without an accepted pop, `valid_out <= 0` and `data_out` holds its value.
- Count update: push only → +1; pop only → −1; both accepted → unchanged.
- Simultaneous push and pop:
  - When empty, only the push is accepted; the pop is an underflow.
  - When full, both are accepted. Count stays 8 and no error is raised.
  - Otherwise both are accepted.
- Overflow: `push` while full without `pop` drops the word, leaves pointers and count unchanged, and sets `error_out`.
- Underflow: `pop` while empty leaves state unchanged and sets `error_out`.
- `error_out` is sticky and is cleared only by `reset`.
- Flags are combinational compares on the registered `count` and the live `bajo`/`alto`. A threshold change takes effect in the same cycle. There is no saturation or clamping; `bajo = 0` makes `almost_empty` equal to `fifo_empty`.

## Timing

- Write to readable: a word pushed at edge N can be popped at edge N+1.
- Read latency: one cycle. A pop at edge N presents the data and `valid_out = 1` after edge N, for one cycle per pop; back-to-back pops stream one word per cycle.
- `count` and all flags update on the edge that performs the push/pop and are valid immediately after it.
- `error_out` asserts on the edge of the offending request.

## Test plan

- Reset check: hold `reset` for 2 cycles with `push = pop = 1`, `alto = 6`, `bajo = 2` → after release `count = 0`, `fifo_empty = 1`, `almost_empty = 1`, `almost_full = 0`, `valid_out = 0`, `error_out = 0`.
- Fill and drain: push 0x01..0x08, then pop 8 times → after the 8th push `fifo_full = 1` and `count = 8`; reads return 0x01..0x08 in order with `valid_out` high for 8 cycles; final `fifo_empty = 1`; `error_out = 0`.
- Thresholds: with `bajo = 2`, `alto = 6`, push one word at a time → `almost_empty` is 1 for count 0..2 and drops at count 3; `almost_full` rises at count 6. Then change `alto` to 4 at count 5 → `almost_full = 1` the same cycle.
- Overflow/underflow: pop while empty → `error_out = 1` and count stays 0. Reset, fill to 8, push 0x3F → `error_out = 1`, count stays 8, and the drain returns no 0x3F.
- Simultaneous push/pop:
  - Full, push 0x2A + pop → `data_out` = oldest word, count stays 8, no error; 0x2A is read last.
  - Empty, push 0x15 + pop → count = 1, `error_out = 1`, `valid_out = 0`.
- Wrap and reset mid-operation: run 20 cycles of alternating push/pop so the pointers wrap twice → data ordering is preserved. Assert `reset` while count = 5 → next cycle count = 0, `fifo_empty = 1`, and the old data is never output.
